gticc_rxlink_mon: RTL and testbench

GTICC_RXLINK_MON -- requirements
Module: gticc_rxlink_mon

---
 rtl/gticc_rxlink_mon_pkg.sv | 20 ++
 rtl/gticc_rxlink_mon_if.sv | 33 +++
 rtl/gticc_rxlane_fsm.sv | 165 ++++++++++++++++
 rtl/gticc_rxlink_mon.sv | 55 +++++
 tb/tb_gticc_rxlink_mon.sv | 328 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/gticc_rxlink_mon_pkg.sv
// Shared types and constants for the GT receive-link monitor.
//   lane_state_e : per-lane lock state
//   ERRCNT_W     : width of each lane's error-cycle counter
//   is_locked()  : decode of the states that report a qualified lock
package gticc_pkg;

  localparam int unsigned ERRCNT_W = 16;

  typedef enum logic [1:0] {
    ST_UNLOCK = 2'd0,
    ST_QUAL   = 2'd1,
    ST_LOCK   = 2'd2,
    ST_HOLD   = 2'd3
  } lane_state_e;

  function automatic logic is_locked(input lane_state_e s);
    return (s == ST_LOCK) || (s == ST_HOLD);
  endfunction

endpackage

// File: rtl/gticc_rxlink_mon_if.sv
// Status bundle between the GT receive lanes and the link monitor.
//   GT side (master) drives : rxcdrlock, rxbyteisaligned, rxdisperr, rxnotintable,
//                             rxuserrdy_in, errclr
//   Monitor (slave) drives  : lane_locked, all_locked, rxuserrdy, rxreset_req, errcnt
// Per-byte error vectors and errcnt are lane-major.
interface gticc_rxlink_mon_if #(
  parameter int unsigned NLANE = 4,
  parameter int unsigned DBYTE = 2
);

  logic [NLANE-1:0]                     rxcdrlock;
  logic [NLANE-1:0]                     rxbyteisaligned;
  logic [NLANE*DBYTE-1:0]               rxdisperr;
  logic [NLANE*DBYTE-1:0]               rxnotintable;
  logic                                 rxuserrdy_in;
  logic                                 errclr;
  logic [NLANE-1:0]                     lane_locked;
  logic                                 all_locked;
  logic                                 rxuserrdy;
  logic [NLANE-1:0]                     rxreset_req;
  logic [NLANE*gticc_pkg::ERRCNT_W-1:0] errcnt;

  modport master (
    output rxcdrlock, rxbyteisaligned, rxdisperr, rxnotintable, rxuserrdy_in, errclr,
    input  lane_locked, all_locked, rxuserrdy, rxreset_req, errcnt
  );

  modport slave (
    input  rxcdrlock, rxbyteisaligned, rxdisperr, rxnotintable, rxuserrdy_in, errclr,
    output lane_locked, all_locked, rxuserrdy, rxreset_req, errcnt
  );

endinterface

// File: rtl/gticc_rxlane_fsm.sv
// One GT receive lane: lock qualification, cdrlock-loss tolerance, windowed
// error threshold with relock request, and an optional error-cycle counter.
// Optional feature macro: GTICC_RXMON_ERRCNT_EN (errcnt counter present).
// Ports:
//   RXUSRCLK, reset (async, active-high)
//   rxcdrlock, rxbyteisaligned     : lane status
//   rxdisperr, rxnotintable [DBYTE]: per-byte code errors
//   errclr                         : synchronous errcnt clear
//   lane_locked                    : decoded from state (LOCK/HOLD)
//   rxreset_req                    : registered one-cycle relock request
//   errcnt [ERRCNT_W]              : saturating error-cycle count
module gticc_rxlane_fsm
  import gticc_pkg::*;
#(
  parameter int unsigned DBYTE   = 2,
  parameter int unsigned LOCKMIN = 8,
  parameter int unsigned LOCKMAX = 3,
  parameter int unsigned ERRWIN  = 1024,
  parameter int unsigned ERRMAX  = 16
) (
  input  logic                RXUSRCLK,
  input  logic                reset,
  input  logic                rxcdrlock,
  input  logic                rxbyteisaligned,
  input  logic [DBYTE-1:0]    rxdisperr,
  input  logic [DBYTE-1:0]    rxnotintable,
  input  logic                errclr,
  output logic                lane_locked,
  output logic                rxreset_req,
  output logic [ERRCNT_W-1:0] errcnt
);

  localparam int unsigned QW = $clog2(LOCKMIN + 1);
  localparam int unsigned UW = $clog2(LOCKMAX + 1);
  localparam int unsigned WW = $clog2(ERRWIN);
  localparam int unsigned EW = $clog2(ERRMAX + 1);

  lane_state_e   state_q, state_d;
  logic [QW-1:0] qual_q, qual_d;
  logic [UW-1:0] unlock_q, unlock_d;
  logic [WW-1:0] win_q, win_d;
  logic [EW-1:0] errs_q, errs_d;
  logic          req_q, req_d;

  logic          good, err, locked, win_last, thresh;
  logic [31:0]   err_sum, unlock_nx;

  assign good      = rxcdrlock & rxbyteisaligned;
  assign err       = |(rxdisperr | rxnotintable);
  assign locked    = is_locked(state_q);
  assign win_last  = (win_q == WW'(ERRWIN - 1));
  // This cycle's error counts toward the current window, including its last cycle.
  assign err_sum   = 32'(errs_q) + 32'(err);
  assign thresh    = locked && (err_sum >= ERRMAX);
  // unlockcnt holds the low cycles seen so far; this low cycle makes it unlock_nx.
  assign unlock_nx = 32'(unlock_q) + 32'd1;

  // State and counter registers.
  always_ff @(posedge RXUSRCLK or posedge reset) begin
    if (reset) begin
      state_q  <= ST_UNLOCK;
      qual_q   <= '0;
      unlock_q <= '0;
      win_q    <= '0;
      errs_q   <= '0;
      req_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      qual_q   <= qual_d;
      unlock_q <= unlock_d;
      win_q    <= win_d;
      errs_q   <= errs_d;
      req_q    <= req_d;
    end
  end

  // Next-state, counters and relock request; the error threshold outranks cdrlock loss.
  always_comb begin
    state_d  = state_q;
    qual_d   = qual_q;
    unlock_d = unlock_q;
    win_d    = win_q;
    errs_d   = errs_q;
    req_d    = 1'b0;

    if (locked) begin
      win_d  = win_last ? '0 : win_q + WW'(1);
      errs_d = win_last ? '0 : EW'(err_sum);
    end

    case (state_q)
      ST_UNLOCK: begin
        if (good) begin
          state_d = ST_QUAL;
          qual_d  = QW'(1);
        end
      end
      ST_QUAL: begin
        if (!good) begin
          state_d = ST_UNLOCK;
          qual_d  = '0;
        end else if (qual_q == QW'(LOCKMIN)) begin
          state_d = ST_LOCK;
          qual_d  = '0;
          win_d   = '0;
          errs_d  = '0;
        end else begin
          qual_d = qual_q + QW'(1);
        end
      end
      ST_LOCK: begin
        if (thresh) begin
          state_d = ST_UNLOCK;
          req_d   = 1'b1;
        end else if (!rxcdrlock) begin
          state_d  = ST_HOLD;
          unlock_d = UW'(1);
        end else if (!rxbyteisaligned) begin
          state_d = ST_UNLOCK;
        end
      end
      ST_HOLD: begin
        if (thresh) begin
          state_d  = ST_UNLOCK;
          req_d    = 1'b1;
          unlock_d = '0;
        end else if (rxcdrlock) begin
          state_d  = ST_LOCK;
          unlock_d = '0;
        end else if (unlock_nx >= LOCKMAX) begin
          state_d  = ST_UNLOCK;
          unlock_d = '0;
        end else begin
          unlock_d = UW'(unlock_nx);
        end
      end
      default: state_d = ST_UNLOCK;
    endcase
  end

  assign lane_locked = locked;
  assign rxreset_req = req_q;

`ifdef GTICC_RXMON_ERRCNT_EN
  logic [ERRCNT_W-1:0] cnt_q;

  // Saturating count of error cycles outside UNLOCK; clear wins over increment.
  always_ff @(posedge RXUSRCLK or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (errclr) begin
      cnt_q <= '0;
    end else if (err && (state_q != ST_UNLOCK) && (cnt_q != '1)) begin
      cnt_q <= cnt_q + ERRCNT_W'(1);
    end
  end

  assign errcnt = cnt_q;
`else
  logic unused_errclr;
  assign unused_errclr = errclr;
  assign errcnt        = '0;
`endif

endmodule

// File: rtl/gticc_rxlink_mon.sv
// GT receive-link monitor: NLANE independent lane lock FSMs plus link-level
// ready gating. Optional feature macro: GTICC_RXMON_ERRCNT_EN (per-lane errcnt).
// Ports:
//   RXUSRCLK : sole clock
//   reset    : async, active-high; caller releases it synchronously
//   mon      : status bundle (slave side) -- lane inputs, lane_locked,
//              all_locked, rxuserrdy, rxreset_req, errcnt
module gticc_rxlink_mon
  import gticc_pkg::*;
#(
  parameter int unsigned NLANE   = 4,
  parameter int unsigned DBYTE   = 2,
  parameter int unsigned LOCKMIN = 8,
  parameter int unsigned LOCKMAX = 3,
  parameter int unsigned ERRWIN  = 1024,
  parameter int unsigned ERRMAX  = 16
) (
  input logic              RXUSRCLK,
  input logic              reset,
  gticc_rxlink_mon_if.slave mon
);

  logic [NLANE-1:0]          lane_locked_w;
  logic [NLANE-1:0]          req_w;
  logic [NLANE*ERRCNT_W-1:0] errcnt_w;

  for (genvar i = 0; i < NLANE; i++) begin : g_lane
    gticc_rxlane_fsm #(
      .DBYTE   (DBYTE),
      .LOCKMIN (LOCKMIN),
      .LOCKMAX (LOCKMAX),
      .ERRWIN  (ERRWIN),
      .ERRMAX  (ERRMAX)
    ) u_lane (
      .RXUSRCLK        (RXUSRCLK),
      .reset           (reset),
      .rxcdrlock       (mon.rxcdrlock[i]),
      .rxbyteisaligned (mon.rxbyteisaligned[i]),
      .rxdisperr       (mon.rxdisperr[i*DBYTE +: DBYTE]),
      .rxnotintable    (mon.rxnotintable[i*DBYTE +: DBYTE]),
      .errclr          (mon.errclr),
      .lane_locked     (lane_locked_w[i]),
      .rxreset_req     (req_w[i]),
      .errcnt          (errcnt_w[i*ERRCNT_W +: ERRCNT_W])
    );
  end

  // Link-level readiness follows lane lock combinationally.
  assign mon.lane_locked = lane_locked_w;
  assign mon.all_locked  = &lane_locked_w;
  assign mon.rxuserrdy   = mon.rxuserrdy_in & (&lane_locked_w);
  assign mon.rxreset_req = req_w;
  assign mon.errcnt      = errcnt_w;

endmodule

// File: tb/tb_gticc_rxlink_mon.sv
// Bench for gticc_rxlink_mon: behavioural lane model compared every cycle,
// directed scenarios with literal expectations, and an errcnt saturation run
// on a second instance held in qualification.
module tb_gticc_rxlink_mon;

  localparam int NL   = 4;
  localparam int DB   = 2;
  localparam int LMIN = 8;
  localparam int LMAX = 3;
  localparam int EWIN = 16;
  localparam int EMAX = 4;
`ifdef GTICC_RXMON_ERRCNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  gticc_rxlink_mon_if #(.NLANE(NL), .DBYTE(DB)) ifa ();
  gticc_rxlink_mon_if #(.NLANE(1),  .DBYTE(DB)) ifb ();

  gticc_rxlink_mon #(
    .NLANE(NL), .DBYTE(DB), .LOCKMIN(LMIN), .LOCKMAX(LMAX), .ERRWIN(EWIN), .ERRMAX(EMAX)
  ) dut_a (
    .RXUSRCLK (clk),
    .reset    (reset),
    .mon      (ifa)
  );

  // Lock qualification long enough that this instance never leaves QUAL here.
  gticc_rxlink_mon #(
    .NLANE(1), .DBYTE(DB), .LOCKMIN(131071), .LOCKMAX(LMAX), .ERRWIN(16), .ERRMAX(16)
  ) dut_b (
    .RXUSRCLK (clk),
    .reset    (reset),
    .mon      (ifb)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model of dut_a ----------------
  // run  : consecutive good cycles while not locked (0 means idle/unlocked)
  // low  : consecutive cdrlock-low cycles while locked
  // age  : cycles spent locked since lock was gained (window position = age % EWIN)
  // werr : error cycles in the current window
  int m_run[NL]  = '{default: 0};
  int m_low[NL]  = '{default: 0};
  int m_age[NL]  = '{default: 0};
  int m_werr[NL] = '{default: 0};
  int m_cnt[NL]  = '{default: 0};
  bit m_lock[NL] = '{default: 1'b0};
  bit m_req[NL]  = '{default: 1'b0};

  always @(posedge clk or posedge reset) begin
    bit cdr, al, good, err, active, lk, rq;
    int r, l, a, w, c;
    if (reset) begin
      for (int i = 0; i < NL; i++) begin
        m_run[i] <= 0; m_low[i] <= 0; m_age[i] <= 0; m_werr[i] <= 0;
        m_cnt[i] <= 0; m_lock[i] <= 1'b0; m_req[i] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < NL; i++) begin
        cdr    = ifa.rxcdrlock[i];
        al     = ifa.rxbyteisaligned[i];
        good   = cdr & al;
        err    = |(ifa.rxdisperr[i*DB +: DB] | ifa.rxnotintable[i*DB +: DB]);
        active = m_lock[i] || (m_run[i] > 0);
        lk = m_lock[i]; r = m_run[i]; l = m_low[i]; a = m_age[i]; w = m_werr[i];
        rq = 1'b0;
        if (!lk) begin
          if (good) begin
            r++;
            if (r == LMIN + 1) begin
              lk = 1'b1; r = 0; a = 0; w = 0; l = 0;
            end
          end else begin
            r = 0;
          end
        end else if (w + int'(err) >= EMAX) begin
          rq = 1'b1; lk = 1'b0; r = 0;
        end else begin
          w = ((a % EWIN) == EWIN - 1) ? 0 : w + int'(err);
          a++;
          if (!cdr) begin
            l++;
            if (l >= LMAX) begin
              lk = 1'b0; r = 0; l = 0;
            end
          end else begin
            if (l == 0 && !al) begin
              lk = 1'b0; r = 0;
            end
            l = 0;
          end
        end
        c = m_cnt[i];
        if (CNT_EN) begin
          if (ifa.errclr) c = 0;
          else if (active && err && c < 65535) c++;
        end
        m_run[i] <= r; m_low[i] <= l; m_age[i] <= a; m_werr[i] <= w;
        m_cnt[i] <= c; m_lock[i] <= lk; m_req[i] <= rq;
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    logic [NL-1:0] el, er;
    logic [63:0]   ec;
    for (int i = 0; i < NL; i++) begin
      el[i] = m_lock[i];
      er[i] = m_req[i];
      ec[i*16 +: 16] = 16'(m_cnt[i]);
    end
    chk("model_lane_locked", 64'(ifa.lane_locked), 64'(el));
    chk("model_all_locked",  64'(ifa.all_locked),  64'(&el));
    chk("model_rxuserrdy",   64'(ifa.rxuserrdy),   64'(ifa.rxuserrdy_in & (&el)));
    chk("model_rxreset_req", 64'(ifa.rxreset_req), 64'(er));
    chk("model_errcnt",      64'(ifa.errcnt),      ec);
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic set_good(input int l, input bit v);
    ifa.rxcdrlock[l]       = v;
    ifa.rxbyteisaligned[l] = v;
  endtask

  task automatic set_err(input int l, input bit v);
    ifa.rxdisperr[l*DB] = v;
  endtask

  // Force a lane out of lock from any state, then requalify it from scratch.
  task automatic relock(input int l);
    set_good(l, 1'b0);
    cyc(LMAX + 1);
    set_good(l, 1'b1);
    cyc(LMIN + 1);
    chk($sformatf("relock_lane%0d", l), 64'(ifa.lane_locked[l]), 64'd1);
  endtask

  initial begin
    bit seen;
    ifa.rxcdrlock = '0; ifa.rxbyteisaligned = '0; ifa.rxdisperr = '0; ifa.rxnotintable = '0;
    ifa.rxuserrdy_in = 1'b0; ifa.errclr = 1'b0;
    ifb.rxcdrlock = '0; ifb.rxbyteisaligned = '0; ifb.rxdisperr = '0; ifb.rxnotintable = '0;
    ifb.rxuserrdy_in = 1'b0; ifb.errclr = 1'b0;

    cyc(2);
    chk("rst_lane_locked", 64'(ifa.lane_locked), 64'd0);
    chk("rst_all_locked",  64'(ifa.all_locked),  64'd0);
    chk("rst_rxreset_req", 64'(ifa.rxreset_req), 64'd0);
    chk("rst_errcnt",      64'(ifa.errcnt),      64'd0);
    reset = 1'b0;

    // Lock qualification: lane 0 continuous, lane 1 interrupted at cycle 5.
    set_good(0, 1'b1);
    cyc(LMIN);
    chk("lane0_edge8", 64'(ifa.lane_locked[0]), 64'd0);
    cyc(1);
    chk("lane0_edge9", 64'(ifa.lane_locked[0]), 64'd1);
    set_good(1, 1'b1);
    cyc(4);
    set_good(1, 1'b0);
    cyc(1);
    chk("lane1_drop", 64'(ifa.lane_locked[1]), 64'd0);
    set_good(1, 1'b1);
    cyc(LMIN);
    chk("lane1_restart_edge8", 64'(ifa.lane_locked[1]), 64'd0);
    cyc(1);
    chk("lane1_restart_edge9", 64'(ifa.lane_locked[1]), 64'd1);

    set_good(2, 1'b1);
    set_good(3, 1'b1);
    cyc(LMIN + 1);
    chk("all_locked_4", 64'(ifa.all_locked), 64'd1);
    ifa.rxuserrdy_in = 1'b1;
    #1;
    chk("rxuserrdy_on", 64'(ifa.rxuserrdy), 64'd1);
    ifa.rxuserrdy_in = 1'b0;
    #1;
    chk("rxuserrdy_in_low", 64'(ifa.rxuserrdy), 64'd0);
    ifa.rxuserrdy_in = 1'b1;

    // cdrlock loss tolerance on lane 0.
    ifa.rxcdrlock[0] = 1'b0;
    cyc(1);
    chk("hold_low1", 64'(ifa.lane_locked[0]), 64'd1);
    cyc(1);
    chk("hold_low2", 64'(ifa.lane_locked[0]), 64'd1);
    ifa.rxcdrlock[0] = 1'b1;
    cyc(1);
    chk("hold_recover", 64'(ifa.lane_locked[0]), 64'd1);
    cyc(2);
    ifa.rxcdrlock[0] = 1'b0;
    cyc(2);
    chk("unlock_low2", 64'(ifa.lane_locked[0]), 64'd1);
    cyc(1);
    chk("unlock_low3", 64'(ifa.lane_locked[0]), 64'd0);
    chk("unlock_noreq", 64'(ifa.rxreset_req), 64'd0);
    chk("unlock_all_locked", 64'(ifa.all_locked), 64'd0);
    cyc(1);
    ifa.rxcdrlock[0] = 1'b1;
    cyc(LMIN + 1);
    chk("lane0_relocked", 64'(ifa.lane_locked[0]), 64'd1);

    // Error threshold on lane 2: four errors in one window.
    relock(2);
    set_err(2, 1'b1);
    cyc(3);
    chk("thr_err3_noreq", 64'(ifa.rxreset_req[2]), 64'd0);
    chk("thr_err3_locked", 64'(ifa.lane_locked[2]), 64'd1);
    cyc(1);
    chk("thr_err4_req", 64'(ifa.rxreset_req[2]), 64'd1);
    chk("thr_err4_unlock", 64'(ifa.lane_locked[2]), 64'd0);
    set_err(2, 1'b0);
    cyc(1);
    chk("thr_req_oneshot", 64'(ifa.rxreset_req[2]), 64'd0);

    // Three errors per window (one on the last cycle) over five windows, then
    // four errors ending on a window's last cycle.
    relock(2);
    seen = 1'b0;
    for (int k = 0; k < 5 * EWIN; k++) begin
      set_err(2, (k % EWIN == 0) || (k % EWIN == 5) || (k % EWIN == EWIN - 1));
      cyc(1);
      seen |= ifa.rxreset_req[2];
    end
    chk("win3_noreq", 64'(seen), 64'd0);
    chk("win3_locked", 64'(ifa.lane_locked[2]), 64'd1);
    for (int k = 0; k < EWIN; k++) begin
      set_err(2, k >= EWIN - 4);
      cyc(1);
      if (k < EWIN - 1) seen |= ifa.rxreset_req[2];
    end
    chk("winlast_early", 64'(seen), 64'd0);
    chk("winlast_req", 64'(ifa.rxreset_req[2]), 64'd1);
    set_err(2, 1'b0);

    // Threshold coincident with cdrlock loss on lane 3.
    relock(3);
    ifa.rxnotintable[3*DB + 1] = 1'b1;
    cyc(3);
    ifa.rxcdrlock[3] = 1'b0;
    cyc(1);
    chk("coinc_req", 64'(ifa.rxreset_req[3]), 64'd1);
    chk("coinc_unlock", 64'(ifa.lane_locked[3]), 64'd0);
    ifa.rxnotintable[3*DB + 1] = 1'b0;
    cyc(1);
    chk("coinc_not_hold", 64'(ifa.lane_locked[3]), 64'd0);
    chk("coinc_oneshot", 64'(ifa.rxreset_req[3]), 64'd0);
    ifa.rxcdrlock[3] = 1'b1;
    cyc(LMIN + 1);

    // Mixed traffic, checked cycle by cycle against the model.
    for (int k = 0; k < 300; k++) begin
      for (int i = 0; i < NL; i++) begin
        ifa.rxcdrlock[i]       = ($urandom_range(19) != 0);
        ifa.rxbyteisaligned[i] = ($urandom_range(29) != 0);
        for (int b = 0; b < DB; b++) begin
          ifa.rxdisperr[i*DB + b]    = ($urandom_range(15) == 0);
          ifa.rxnotintable[i*DB + b] = ($urandom_range(23) == 0);
        end
      end
      ifa.errclr       = ($urandom_range(39) == 0);
      ifa.rxuserrdy_in = ($urandom_range(7) != 0);
      cyc(1);
    end
    ifa.rxdisperr = '0; ifa.rxnotintable = '0; ifa.errclr = 1'b0; ifa.rxuserrdy_in = 1'b1;
    ifa.rxcdrlock = '0; ifa.rxbyteisaligned = '0;
    cyc(LMAX + 1);
    ifa.rxcdrlock = '1; ifa.rxbyteisaligned = '1;
    cyc(LMIN + 1);
    chk("pre_reset_all_locked", 64'(ifa.all_locked), 64'd1);
    chk("pre_reset_rxuserrdy", 64'(ifa.rxuserrdy), 64'd1);

    // Asynchronous reset between edges.
    reset = 1'b1;
    #1;
    chk("areset_lane_locked", 64'(ifa.lane_locked), 64'd0);
    chk("areset_all_locked",  64'(ifa.all_locked),  64'd0);
    chk("areset_rxuserrdy",   64'(ifa.rxuserrdy),   64'd0);
    chk("areset_rxreset_req", 64'(ifa.rxreset_req), 64'd0);
    chk("areset_errcnt",      64'(ifa.errcnt),      64'd0);
    cyc(2);
    reset = 1'b0;

    // Error counter on dut_b: first edge enters QUAL, later edges count.
    ifb.rxcdrlock[0] = 1'b1;
    ifb.rxbyteisaligned[0] = 1'b1;
    ifb.rxdisperr[0] = 1'b1;
    cyc(100);
    chk("errcnt_99", 64'(ifb.errcnt), CNT_EN ? 64'd99 : 64'd0);
    if (CNT_EN) cyc(70000);
    else        cyc(200);
    chk("errcnt_sat", 64'(ifb.errcnt), CNT_EN ? 64'hFFFF : 64'd0);
    ifb.errclr = 1'b1;
    cyc(1);
    chk("errcnt_clr", 64'(ifb.errcnt), 64'd0);
    ifb.errclr = 1'b0;
    cyc(1);
    chk("errcnt_after_clr", 64'(ifb.errcnt), CNT_EN ? 64'd1 : 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
